dmem_sram_resp: RTL and testbench

Data-memory responder at the far end of the processor's SRAM-style data interface (CEN/WEN/OEN/A/write-data/read-data).
Holds DEPTH words and services one read or write per cycle, with a parameterised pipelined read latency.
On reset it optionally sweeps the whole array to zero, asserting busy while it does so.
Sits between the core's data-memory port and the top level, replacing the bench SRAM model.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_rd_pipe.sv | 49 ++++
 rtl/dmem_sram_resp.sv | 92 +++++++++
 tb/tb_dmem_sram_resp.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared defaults and types for the data-memory responder.
// Imported by the array top and its read pipeline.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 128;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read-data delay line with a valid bit per stage and synchronous flush.
// Stage data only loads with valid, so the last stage holds the last result.
module dmem_rd_pipe
  import dmem_pkg::*;
#(
  parameter int LAT = 1,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         flush_i,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  for (genvar i = 0; i < LAT; i++) begin : g_stg
    logic         v_q;
    logic [W-1:0] d_q;

    if (i == 0) begin : g_head
      // First stage captures the word sampled at the issue edge
      always_ff @(posedge clk) begin
        if (flush_i) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= vld_i;
          if (vld_i) d_q <= dat_i;
        end
      end
    end else begin : g_tail
      // Later stages shift the previous stage forward
      always_ff @(posedge clk) begin
        if (flush_i) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= g_stg[i-1].v_q;
          if (g_stg[i-1].v_q) d_q <= g_stg[i-1].d_q;
        end
      end
    end
  end

  assign vld_o = g_stg[LAT-1].v_q;
  assign dat_o = g_stg[LAT-1].d_q;

endmodule

// File: rtl/dmem_sram_resp.sv
// SRAM-style data-memory responder: one access per cycle,
// pipelined read latency and an optional zero sweep after reset.
module dmem_sram_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = DMEM_ADDR_W,
  parameter int DATA_W         = DMEM_DATA_W,
  parameter int DEPTH          = DMEM_DEPTH,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              rd_valid,
  output logic              busy
);

  if (READ_LAT < RD_LAT_MIN || READ_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("READ_LAT must be within 1..4");
  end
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;

  logic              rd_issue;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] hold;

  // Write port is shared by the clear sweep and normal writes
  always_comb begin
    rd_issue = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = A;
    wr_data  = D;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = '0;
      end else if (!CEN) begin
        wr_en    = !WEN;
        rd_issue = WEN;
      end
    end
  end

  // Clear sweep state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      ptr_q   <= '0;
    end else if (state_q == ST_CLEAR) begin
      ptr_q <= ptr_q + 1'b1;
      if (ptr_q == PTR_LAST) state_q <= ST_RUN;
    end
  end

  // Storage array, never reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  dmem_rd_pipe #(
    .LAT (READ_LAT),
    .W   (DATA_W)
  ) u_rd_pipe (
    .clk     (clk),
    .flush_i (rst),
    .vld_i   (rd_issue),
    .dat_i   (mem_q[A]),
    .vld_o   (rd_valid),
    .dat_o   (hold)
  );

  assign Q    = OEN ? '0 : hold;
  assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dmem_sram_resp.sv
// Scoreboard bench: a latency-3 clearing instance and a latency-1
// non-clearing instance share one randomized/directed stimulus stream.
module tb_dmem_sram_resp;

  localparam int N = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CEN = 1'b1;
  logic        WEN = 1'b1;
  logic        OEN = 1'b0;
  logic [6:0]  A   = '0;
  logic [31:0] D   = '0;

  logic [31:0] q1, q3;
  logic        v1, v3, b1, b3;

  always #5 clk = ~clk;

  dmem_sram_resp #(
    .READ_LAT       (1),
    .CLEAR_ON_RESET (0)
  ) u_l1 (
    .clk (clk), .rst (rst), .CEN (CEN), .WEN (WEN), .OEN (OEN),
    .A (A), .D (D), .Q (q1), .rd_valid (v1), .busy (b1)
  );

  dmem_sram_resp #(
    .READ_LAT       (3),
    .CLEAR_ON_RESET (1)
  ) u_l3 (
    .clk (clk), .rst (rst), .CEN (CEN), .WEN (WEN), .OEN (OEN),
    .A (A), .D (D), .Q (q3), .rd_valid (v3), .busy (b3)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb [2][$];
  logic [31:0] mem1 [N];
  logic [31:0] mem3 [N];
  logic [31:0] last [2];
  int          rem = 0;
  int          cyc = 0;
  int          npass = 0;
  int          nchk = 0;
  bit          armed = 1'b0;
  bit          exp_busy = 1'b0;
  bit          oen_v = 1'b0;
  logic        rst_e = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_e <= rst;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d",
                  nm, act, exp, cyc);
  endfunction

  // Drive one cycle and advance the reference model across its edge
  task automatic step(input bit r, input bit c, input bit w, input bit o,
                      input logic [6:0] a, input logic [31:0] d);
    exp_busy = (rem > 0);
    rst = r; CEN = c; WEN = w; OEN = o; A = a; D = d;
    if (r) begin
      rem = N;
      foreach (mem3[i]) mem3[i] = '0;
      for (int k = 0; k < 2; k++)
        while (sb[k].size() > 0 && sb[k][sb[k].size()-1].due > cyc)
          void'(sb[k].pop_back());
    end else begin
      if (!c && !w) begin
        mem1[a] = d;
        if (rem == 0) mem3[a] = d;
      end else if (!c && w) begin
        sb[0].push_back('{mem1[a], cyc + 1});
        if (rem == 0) sb[1].push_back('{mem3[a], cyc + 3});
      end
      if (rem > 0) rem--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b1, oen_v, 7'd0, 32'd0);
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, 1'b0, oen_v, a, d);
  endtask

  task automatic rd(input logic [6:0] a);
    step(1'b0, 1'b0, 1'b1, oen_v, a, $urandom);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b1, oen_v, 7'd9, 32'd0);
  endtask

  // Monitor: pops expected returns and compares DUT outputs each cycle
  always @(negedge clk) begin
    exp_t        e;
    logic        vv;
    logic [31:0] qv;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        vv = (k == 0) ? v1 : v3;
        qv = (k == 0) ? q1 : q3;
        if (rst_e) last[k] = '0;
        if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
          e = sb[k].pop_front();
          check(k == 0 ? "l1_rd_valid" : "l3_rd_valid", {31'd0, vv}, 32'd1);
          last[k] = e.data;
        end else begin
          check(k == 0 ? "l1_no_valid" : "l3_no_valid", {31'd0, vv}, 32'd0);
        end
        check(k == 0 ? "l1_Q" : "l3_Q", qv, OEN ? 32'd0 : last[k]);
      end
      check("l3_busy", {31'd0, b3}, {31'd0, exp_busy});
      check("l1_busy", {31'd0, b1}, 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          r, c, w;
    logic [6:0]  a;
    logic [31:0] d;
    last[0] = '0;
    last[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    armed = 1'b1;
    idle(130);

    for (int i = 0; i < N; i++) wr(7'(i), 32'hFFFF_FFFF);
    rd(7'd0); rd(7'd64); rd(7'd127);
    idle(4);
    do_reset();
    idle(130);
    rd(7'd0); rd(7'd64); rd(7'd127);
    idle(4);

    wr(7'd5, 32'hDEAD_BEEF);
    rd(7'd5);
    idle(4);

    wr(7'd1, 32'h11); wr(7'd2, 32'h22); wr(7'd3, 32'h33);
    rd(7'd1); rd(7'd2); rd(7'd3);
    idle(4);

    wr(7'd7, 32'h1);
    rd(7'd7);
    wr(7'd7, 32'h2);
    idle(4);
    rd(7'd7);
    idle(4);

    wr(7'd20, 32'hCAFE_F00D);
    oen_v = 1'b1;
    rd(7'd20);
    idle(4);
    oen_v = 1'b0;
    idle(2);

    rd(7'd1); rd(7'd2);
    do_reset();
    idle(5);
    wr(7'd9, 32'h5);
    while (rem > N - 40) idle(1);
    do_reset();
    idle(130);
    rd(7'd9);
    idle(4);

    repeat (2000) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 3) == 0);
      w = 1'($urandom_range(0, 1));
      oen_v = ($urandom_range(0, 9) == 0);
      a = 7'($urandom_range(0, 15));
      d = $urandom;
      step(r, c, w, oen_v, a, d);
    end
    oen_v = 1'b0;
    idle(10);
    check("sb_drain", 32'(sb[0].size() + sb[1].size()), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
